// File: rtl/div_if.sv
// div_if: start/done handshake and operand/result bundle for the shift-subtract divider
interface div_if #(
  parameter int DIVIDEND_W = 16,
  parameter int DIVISOR_W = 8
);
  logic start;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0] divisor;
  logic busy;
  logic done;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0] remainder;
  logic div_by_zero;
  modport master (
    output start, dividend, divisor,
    input busy, done, quotient, remainder, div_by_zero
  );
  modport slave (
    input start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/shift_subtract_divider.sv
// shift_subtract_divider: sequential unsigned restoring divider, one quotient bit per clock
module shift_subtract_divider #(
  parameter int DIVIDEND_W = 16,
  parameter int DIVISOR_W = 8
) (
  input logic clk,
  input logic rst,
  div_if.slave d
);
  localparam int CW = $clog2(DIVIDEND_W + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic [DIVISOR_W:0] pr;
  logic [DIVIDEND_W-1:0] sr;
  logic [DIVISOR_W-1:0] dv;
  logic [DIVISOR_W+1:0] sh;
  logic [DIVISOR_W:0] nx;
  logic ge;
  // the extra partial-remainder bit keeps divisors >= 2^(DIVISOR_W-1) from overflowing
  assign sh = {pr, sr[DIVIDEND_W-1]};
  assign ge = sh >= (DIVISOR_W+2)'(dv);
  assign nx = (DIVISOR_W+1)'(ge ? sh - (DIVISOR_W+2)'(dv) : sh);
  assign d.busy = state == RUN;
  assign d.done = state == DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      pr <= '0;
      sr <= '0;
      dv <= '0;
      d.quotient <= '0;
      d.remainder <= '0;
      d.div_by_zero <= 1'b0;
    end else if (state != RUN && d.start) begin
      sr <= d.dividend;
      dv <= d.divisor;
      pr <= '0;
      cnt <= CW'(DIVIDEND_W - 1);
      if (d.divisor == '0) begin
        state <= DONE;
        d.quotient <= '1;
        d.remainder <= '0;
        d.div_by_zero <= 1'b1;
      end else begin
        state <= RUN;
      end
    end else if (state == RUN) begin
      pr <= nx;
      sr <= {sr[DIVIDEND_W-2:0], ge};
      cnt <= cnt - CW'(1);
      if (cnt == '0) begin
        state <= DONE;
        d.quotient <= {sr[DIVIDEND_W-2:0], ge};
        d.remainder <= nx[DIVISOR_W-1:0];
        d.div_by_zero <= 1'b0;
      end
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_shift_subtract_divider.sv
// tb_shift_subtract_divider: table vectors plus corner sequences, checked through a result scoreboard
module tb_shift_subtract_divider;
  localparam int DW = 16;
  localparam int VW = 8;
  typedef struct {
    logic [DW-1:0] a;
    logic [VW-1:0] b;
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic z;
  } vec_t;
  typedef struct {
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic z;
    int c0;
    int lat;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  exp_t exp_q[$];
  vec_t tbl[12];
  div_if #(.DIVIDEND_W(DW), .DIVISOR_W(VW)) d ();
  shift_subtract_divider #(.DIVIDEND_W(DW), .DIVISOR_W(VW)) dut (.clk(clk), .rst(rst), .d(d));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (d.done) begin
      if (exp_q.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("quotient", 32'(d.quotient), 32'(e.q));
        chk("remainder", 32'(d.remainder), 32'(e.r));
        chk("div_by_zero", 32'(d.div_by_zero), 32'(e.z));
        chk("latency", 32'(cyc - e.c0), 32'(e.lat));
        chk("busy_at_done", 32'(d.busy), 0);
      end
    end
  end

  task automatic op(input logic [DW-1:0] a, input logic [VW-1:0] b,
                    input logic [DW-1:0] q, input logic [VW-1:0] r, input logic z);
    @(negedge clk);
    d.start = 1'b1;
    d.dividend = a;
    d.divisor = b;
    @(posedge clk);
    #1;
    exp_q.push_back('{q: q, r: r, z: z, c0: cyc, lat: (b == 0) ? 0 : DW});
    d.start = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(posedge clk);
    if (exp_q.size() != 0) begin
      chk("done_timeout", 1, 0);
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic chk_idle(input string n);
    chk({n, "_busy"}, 32'(d.busy), 0);
    chk({n, "_done"}, 32'(d.done), 0);
    chk({n, "_q"}, 32'(d.quotient), 0);
    chk({n, "_r"}, 32'(d.remainder), 0);
    chk({n, "_z"}, 32'(d.div_by_zero), 0);
  endtask

  initial begin
    tbl[0] = '{16'd42, 8'd7, 16'd6, 8'd0, 1'b0};
    tbl[1] = '{16'd100, 8'd7, 16'd14, 8'd2, 1'b0};
    tbl[2] = '{16'd65535, 8'd255, 16'd257, 8'd0, 1'b0};
    tbl[3] = '{16'd200, 8'd255, 16'd0, 8'd200, 1'b0};
    tbl[4] = '{16'd0, 8'd9, 16'd0, 8'd0, 1'b0};
    tbl[5] = '{16'd1234, 8'd0, 16'hFFFF, 8'd0, 1'b1};
    tbl[6] = '{16'd15, 8'd5, 16'd3, 8'd0, 1'b0};
    tbl[7] = '{16'd1000, 8'd1, 16'd1000, 8'd0, 1'b0};
    tbl[8] = '{16'd65535, 8'd1, 16'd65535, 8'd0, 1'b0};
    tbl[9] = '{16'd65535, 8'd128, 16'd511, 8'd127, 1'b0};
    tbl[10] = '{16'd65535, 8'd200, 16'd327, 8'd135, 1'b0};
    tbl[11] = '{16'd40000, 8'd200, 16'd200, 8'd0, 1'b0};
    d.start = 1'b0;
    d.dividend = '0;
    d.divisor = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;
    op(16'd42, 8'd7, 16'd6, 8'd0, 1'b0);
    @(negedge clk);
    chk("busy_after_start", 32'(d.busy), 1);
    drain();
    for (int i = 0; i < 12; i++) begin
      op(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].z);
      drain();
    end
    for (int i = 0; i < 10; i++) begin
      logic [DW-1:0] a;
      logic [VW-1:0] b;
      a = DW'($urandom);
      b = VW'($urandom_range(1, 255));
      op(a, b, a / DW'(b), VW'(a % DW'(b)), 1'b0);
      drain();
    end
    op(16'd75, 8'd5, 16'd15, 8'd0, 1'b0);
    repeat (5) @(negedge clk);
    d.start = 1'b1;
    d.dividend = 16'd9;
    d.divisor = 8'd3;
    @(negedge clk);
    d.start = 1'b0;
    d.dividend = 16'd777;
    d.divisor = 8'd11;
    drain();
    repeat (20) @(posedge clk);
    op(16'd100, 8'd10, 16'd10, 8'd0, 1'b0);
    begin
      int k;
      for (k = 0; k < 40 && !d.done; k++) @(negedge clk);
      if (!d.done) chk("b2b_wait", 1, 0);
    end
    d.start = 1'b1;
    d.dividend = 16'd24;
    d.divisor = 8'd8;
    @(posedge clk);
    #1;
    exp_q.push_back('{q: 16'd3, r: 8'd0, z: 1'b0, c0: cyc, lat: DW});
    d.start = 1'b0;
    drain();
    op(16'd6000, 8'd60, 16'd100, 8'd0, 1'b0);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    chk_idle("abort");
    repeat (25) @(negedge clk);
    op(16'd6000, 8'd60, 16'd100, 8'd0, 1'b0);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
